// File: rtl/fifo_byte_packer.sv
// Drains bytes from an 8-bit FIFO read port and packs BYTES_PER_WORD of them,
// LSB first, into one word on a valid/ready port; flush emits a partial word.
module fifo_byte_packer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int CNT_W          = $clog2(BYTES_PER_WORD + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        empty,
    input  logic [7:0]                  data_out,
    output logic                        Read_enable,
    input  logic                        flush,
    output logic [8*BYTES_PER_WORD-1:0] word_out,
    output logic [CNT_W-1:0]            word_bytes,
    output logic                        word_valid,
    input  logic                        word_ready
);

    localparam int OW = CNT_W + 1;
    localparam logic [OW-1:0] FULL = OW'(BYTES_PER_WORD);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                              state, state_nxt;
    logic [CNT_W-1:0]                    count;
    logic                                pending;
    logic                                flush_lat, flush_lat_nxt;
    logic                                go_hold;
    logic [BYTES_PER_WORD-1:0][7:0]      lanes;
    logic [OW-1:0]                       occ;

    // Bytes owned by this word: captured plus the one still in flight.
    assign occ        = {1'b0, count} + OW'(pending);
    assign word_out   = lanes;
    assign word_valid = (state == HOLD);

    always_comb begin
        state_nxt     = state;
        flush_lat_nxt = flush_lat;
        go_hold       = 1'b0;
        Read_enable   = reset && (state == FILL) && !empty && !flush_lat && (occ < FULL);
        case (state)
            FILL: begin
                // A latched flush blocks reads, so after this cycle's capture nothing is in flight.
                if (occ == FULL || (flush_lat && occ != '0)) begin
                    go_hold   = 1'b1;
                    state_nxt = HOLD;
                end else if (flush && occ != '0) begin
                    flush_lat_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    state_nxt     = FILL;
                    flush_lat_nxt = 1'b0;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FILL;
            count      <= '0;
            pending    <= 1'b0;
            flush_lat  <= 1'b0;
            lanes      <= '0;
            word_bytes <= '0;
        end else begin
            state     <= state_nxt;
            flush_lat <= flush_lat_nxt;
            pending   <= Read_enable;
            if (state == HOLD && word_ready) begin
                count      <= '0;
                lanes      <= '0;
                word_bytes <= '0;
            end else begin
                count <= CNT_W'(occ);
                for (int i = 0; i < BYTES_PER_WORD; i++) begin
                    if (pending && count == CNT_W'(i)) lanes[i] <= data_out;
                end
                if (go_hold) word_bytes <= CNT_W'(occ);
            end
        end
    end

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Bench for fifo_byte_packer: behavioural FIFO feeding the packer, word scoreboard,
// table of packing vectors and hand-timed flush / reset / backpressure sequences.
module tb_fifo_byte_packer;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           empty = 1'b1;
    logic [7:0]     data_out = 8'h00;
    logic           Read_enable;
    logic           flush = 1'b0;
    logic [8*N-1:0] word_out;
    logic [CW-1:0]  word_bytes;
    logic           word_valid;
    logic           word_ready = 1'b0;

    typedef struct {
        logic [8*N-1:0] w;
        logic [CW-1:0]  b;
    } exp_t;

    typedef struct {
        logic [31:0]   bytes;
        int            n;
        bit            do_flush;
        logic [31:0]   exp_w;
        logic [CW-1:0] exp_b;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] fq[$];
    logic [7:0] push_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;
    int valid_cycles = 0;

    fifo_byte_packer #(.BYTES_PER_WORD(N)) dut (
        .clk(clk), .reset(reset), .empty(empty), .data_out(data_out),
        .Read_enable(Read_enable), .flush(flush), .word_out(word_out),
        .word_bytes(word_bytes), .word_valid(word_valid), .word_ready(word_ready)
    );

    always #5 clk = ~clk;

    // Synchronous FIFO model: read data appears the cycle after Read_enable.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fq.delete();
            push_q.delete();
            data_out <= 8'h00;
            empty    <= 1'b1;
        end else begin
            if (Read_enable && fq.size() > 0) data_out <= fq.pop_front();
            while (push_q.size() > 0) fq.push_back(push_q.pop_front());
            empty <= (fq.size() == 0);
        end
    end

    // Scoreboard and protocol monitor, sampled mid-cycle.
    logic           stall_prev = 1'b0;
    logic [8*N-1:0] w_prev;
    logic [CW-1:0]  b_prev;
    always @(negedge clk) begin
        if (reset) begin
            if (Read_enable && empty) begin
                err_cnt++;
                $display("FAIL re_while_empty: Read_enable=1 with empty=1 at %0t", $time);
            end
            if (Read_enable && word_valid) begin
                err_cnt++;
                $display("FAIL re_in_hold: Read_enable=1 while word_valid=1 at %0t", $time);
            end
            if (word_valid) valid_cycles++;
            if (stall_prev && (!word_valid || word_out !== w_prev || word_bytes !== b_prev)) begin
                err_cnt++;
                $display("FAIL hold_stable: got v=%0b w=%h b=%0d, required v=1 w=%h b=%0d",
                         word_valid, word_out, word_bytes, w_prev, b_prev);
            end
            if (word_valid && word_ready) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL unexpected_word: got w=%h b=%0d, required no word", word_out, word_bytes);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (word_out !== e.w || word_bytes !== e.b) begin
                        err_cnt++;
                        $display("FAIL word: got w=%h b=%0d, required w=%h b=%0d",
                                 word_out, word_bytes, e.w, e.b);
                    end
                end
            end
            stall_prev = word_valid && !word_ready;
            w_prev     = word_out;
            b_prev     = word_bytes;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic expect_word(input logic [8*N-1:0] w, input logic [CW-1:0] b);
        exp_t e;
        e.w = w;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string nm);
        int i;
        for (i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !word_valid) break;
            tick();
        end
        check({nm, "_drain_timeout"}, 64'(i < 300), 64'd1);
    endtask

    task automatic wait_re(input string nm);
        int i;
        for (i = 0; i < 20; i++) begin
            if (Read_enable) break;
            tick();
        end
        check({nm, "_re_timeout"}, 64'(Read_enable), 64'd1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{32'h44332211, 4, 1'b0, 32'h44332211, CW'(4)};
        vt[1] = '{32'h00006B5A, 2, 1'b1, 32'h00006B5A, CW'(2)};
        vt[2] = '{32'h00C3B2A1, 3, 1'b1, 32'h00C3B2A1, CW'(3)};
        vt[3] = '{32'h0000007E, 1, 1'b1, 32'h0000007E, CW'(1)};
        vt[4] = '{32'hFFFFFFFF, 4, 1'b0, 32'hFFFFFFFF, CW'(4)};
        vt[5] = '{32'h00000000, 4, 1'b0, 32'h00000000, CW'(4)};

        // Reset state
        #2;
        check("rst_re",    64'(Read_enable), 64'd0);
        check("rst_valid", 64'(word_valid),  64'd0);
        check("rst_word",  64'(word_out),    64'd0);
        check("rst_bytes", 64'(word_bytes),  64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Table-driven packing vectors
        word_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vt[v].n; i++) push_q.push_back(vt[v].bytes[8*i +: 8]);
            expect_word(vt[v].exp_w, vt[v].exp_b);
            repeat (8) tick();
            if (vt[v].do_flush) pulse_flush();
            wait_drain("table");
        end

        // Basic pack latency: valid 5 cycles after the first read, for one cycle
        begin
            int lat;
            push_q = '{8'h11, 8'h22, 8'h33, 8'h44};
            expect_word(32'h44332211, CW'(4));
            wait_re("basic");
            lat = 0;
            while (!word_valid && lat < 20) begin
                tick();
                lat++;
            end
            check("basic_latency", 64'(lat), 64'd5);
            tick();
            check("basic_one_cycle", 64'(word_valid), 64'd0);
            wait_drain("basic");
        end

        // Flush on the exact cycle of the final capture is consumed by the full word
        push_q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        expect_word(32'hD4D3D2D1, CW'(4));
        wait_re("flush_full");
        repeat (4) tick();
        pulse_flush();
        wait_drain("flush_full");
        repeat (10) tick();
        check("flush_full_no_extra", 64'(word_valid), 64'd0);

        // Partial flush the cycle after the second Read_enable
        push_q = '{8'h5A, 8'h6B};
        expect_word(32'h00006B5A, CW'(2));
        wait_re("partial");
        tick();
        tick();
        pulse_flush();
        wait_drain("partial");

        // Flush with nothing captured or pending is ignored
        begin
            int vc;
            repeat (5) tick();
            vc = valid_cycles;
            pulse_flush();
            repeat (10) tick();
            check("flush_idle_ignored", 64'(valid_cycles), 64'(vc));
        end

        // Backpressure, plus flush in HOLD not queued
        word_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_q.push_back(8'(i));
        expect_word(32'h04030201, CW'(4));
        expect_word(32'h08070605, CW'(4));
        repeat (20) tick();
        check("bp_valid", 64'(word_valid), 64'd1);
        check("bp_word",  64'(word_out),   64'h04030201);
        pulse_flush();
        repeat (3) tick();
        word_ready = 1'b1;
        wait_drain("backpressure");
        repeat (10) tick();
        check("hold_flush_dropped", 64'(word_valid), 64'd0);

        // Empty stall mid-word
        push_q = '{8'hA1, 8'hA2};
        expect_word(32'hA4A3A2A1, CW'(4));
        repeat (20) tick();
        check("stall_no_valid", 64'(word_valid), 64'd0);
        push_q = '{8'hA3, 8'hA4};
        wait_drain("stall");

        // Reset asserted between edges with 3 bytes captured
        push_q = '{8'hE1, 8'hE2, 8'hE3};
        repeat (8) tick();
        check("pre_rst_partial", 64'(word_out), 64'h00E3E2E1);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_re",    64'(Read_enable), 64'd0);
        check("mid_rst_valid", 64'(word_valid),  64'd0);
        check("mid_rst_word",  64'(word_out),    64'd0);
        check("mid_rst_bytes", 64'(word_bytes),  64'd0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        push_q = '{8'hF1, 8'hF2, 8'hF3, 8'hF4};
        expect_word(32'hF4F3F2F1, CW'(4));
        wait_drain("after_rst");

        // Stress: random push timing and random word_ready over 1000 bytes
        begin
            int pushed;
            logic [31:0] wbuf;
            logic [7:0]  b;
            pushed = 0;
            wbuf   = '0;
            while (pushed < 1000) begin
                if ($urandom_range(0, 1) == 1) begin
                    b = 8'($urandom);
                    push_q.push_back(b);
                    wbuf[8*(pushed % 4) +: 8] = b;
                    pushed++;
                    if (pushed % 4 == 0) expect_word(wbuf, CW'(4));
                end
                word_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            word_ready = 1'b1;
            wait_drain("stress");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
